// File: rtl/nibble_comp_pkg.sv
// Shared types and width helpers for the chunk-loaded magnitude comparator.
package nibble_comp_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  function automatic int op_width(input int din_w, input int nchunk);
    return din_w * nchunk;
  endfunction

  function automatic int ptr_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button synchroniser followed by a rising-edge detector; one pulse per press,
// pulse is visible SYNC_STAGES edges after the button rises and acts on the next edge.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/nibble_load_comp.sv
// Operands loaded chunk-by-chunk from switches, then compared serially MSB chunk first.
// Result appears NCHUNK cycles after the write that fills both operands; loads during a compare are dropped.
module nibble_load_comp
  import nibble_comp_pkg::*;
#(
  parameter int DIN_W       = 4,
  parameter int NCHUNK      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIN_W-1:0] y,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             signed_mode,
  output logic             l0,
  output logic             l1,
  output logic             l2,
  output logic             valid,
  output logic             busy
);

  localparam int              W    = op_width(DIN_W, NCHUNK);
  localparam int              PW   = ptr_width(NCHUNK);
  localparam logic [PW-1:0]   LAST = PW'(NCHUNK - 1);

  logic             pulse_a, pulse_b;
  state_t           state, state_nxt;
  logic [W-1:0]     a_reg, b_reg;
  logic [PW-1:0]    ptr_a, ptr_b, idx;
  logic             full_a, full_b, sgn, decided, gt_r;
  logic             take_a, take_b, full_a_nxt, full_b_nxt, start;
  logic [DIN_W-1:0] ca, cb;
  logic             dec_now, gt_now;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .reset(reset), .btn(ld_a), .pulse(pulse_a)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .reset(reset), .btn(ld_b), .pulse(pulse_b)
  );

  always_comb begin
    take_a     = pulse_a && (state != COMPARE);
    take_b     = pulse_b && (state != COMPARE);
    full_a_nxt = take_a ? (ptr_a == LAST) : full_a;
    full_b_nxt = take_b ? (ptr_b == LAST) : full_b;
    start      = (take_a || take_b) && full_a_nxt && full_b_nxt;

    ca = a_reg[int'(idx)*DIN_W +: DIN_W];
    cb = b_reg[int'(idx)*DIN_W +: DIN_W];
    // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
    if (sgn && (idx == LAST)) begin
      ca[DIN_W-1] = ~ca[DIN_W-1];
      cb[DIN_W-1] = ~cb[DIN_W-1];
    end
    dec_now = decided | (ca != cb);
    gt_now  = decided ? gt_r : (ca > cb);

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COMPARE;
      COMPARE: if (idx == '0) state_nxt = DONE;
      DONE: begin
        if (start)                 state_nxt = COMPARE;
        else if (take_a || take_b) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      ptr_a   <= '0;
      ptr_b   <= '0;
      full_a  <= 1'b0;
      full_b  <= 1'b0;
      idx     <= '0;
      sgn     <= 1'b0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      l0      <= 1'b0;
      l1      <= 1'b0;
      l2      <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (take_a) begin
        a_reg[int'(ptr_a)*DIN_W +: DIN_W] <= y;
        ptr_a  <= (ptr_a == LAST) ? '0 : ptr_a + PW'(1);
        full_a <= full_a_nxt;
      end
      if (take_b) begin
        b_reg[int'(ptr_b)*DIN_W +: DIN_W] <= y;
        ptr_b  <= (ptr_b == LAST) ? '0 : ptr_b + PW'(1);
        full_b <= full_b_nxt;
      end
      if (take_a || take_b) begin
        valid <= 1'b0;
        l0    <= 1'b0;
        l1    <= 1'b0;
        l2    <= 1'b0;
      end
      if (start) begin
        busy    <= 1'b1;
        sgn     <= signed_mode;
        idx     <= LAST;
        decided <= 1'b0;
        gt_r    <= 1'b0;
      end
      if (state == COMPARE) begin
        decided <= dec_now;
        gt_r    <= gt_now;
        if (idx == '0) begin
          l0    <= dec_now & ~gt_now;
          l1    <= ~dec_now;
          l2    <= dec_now & gt_now;
          valid <= 1'b1;
          busy  <= 1'b0;
        end else begin
          idx <= idx - PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_load_comp.sv
// Bench for nibble_load_comp: two instances (2 and 4 chunks), scoreboard of expected results and cycles.
module tb_nibble_load_comp;
  import nibble_comp_pkg::*;

  localparam int SYNC = 2;

  typedef struct {
    logic [2:0] res;
    int         due;
  } exp_t;

  logic       clk;
  logic       reset  [2];
  logic [3:0] y      [2];
  logic       ld_a   [2];
  logic       ld_b   [2];
  logic       sm     [2];
  logic       l0     [2];
  logic       l1     [2];
  logic       l2     [2];
  logic       valid  [2];
  logic       busy   [2];
  logic       pv     [2];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q [2][$];

  int nch   [2];
  int ma    [2];
  int mb    [2];
  int pa    [2];
  int pb    [2];
  bit fa    [2];
  bit fb    [2];
  int cmp_e [2];

  nibble_load_comp #(.DIN_W(4), .NCHUNK(2), .SYNC_STAGES(SYNC)) u_dut0 (
    .clk(clk), .reset(reset[0]), .y(y[0]), .ld_a(ld_a[0]), .ld_b(ld_b[0]),
    .signed_mode(sm[0]), .l0(l0[0]), .l1(l1[0]), .l2(l2[0]), .valid(valid[0]), .busy(busy[0])
  );

  nibble_load_comp #(.DIN_W(4), .NCHUNK(4), .SYNC_STAGES(SYNC)) u_dut1 (
    .clk(clk), .reset(reset[1]), .y(y[1]), .ld_a(ld_a[1]), .ld_b(ld_b[1]),
    .signed_mode(sm[1]), .l0(l0[1]), .l1(l1[1]), .l2(l2[1]), .valid(valid[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ordering from plain integer arithmetic; result packed as {l0,l1,l2}.
  function automatic logic [2:0] ref_cmp(input int a, input int b, input int w, input bit s);
    longint sa, sb;
    sa = a;
    sb = b;
    if (s) begin
      if (a >= (1 << (w - 1))) sa = longint'(a) - (longint'(1) << w);
      if (b >= (1 << (w - 1))) sb = longint'(b) - (longint'(1) << w);
    end
    if (sa < sb)       return 3'b100;
    else if (sa == sb) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic model_reset(input int k);
    ma[k] = 0; mb[k] = 0; pa[k] = 0; pb[k] = 0;
    fa[k] = 0; fb[k] = 0; cmp_e[k] = -1000;
    exp_q[k].delete();
  endtask

  // Called at a negedge. Button rises now; the load acts SYNC+1 edges later.
  task automatic press(input int k, input bit da, input bit db, input logic [3:0] val, input int hold);
    int p;
    bit drop;
    p    = cyc + SYNC + 1;
    drop = (p > cmp_e[k]) && (p <= cmp_e[k] + nch[k]);
    if (!drop) begin
      if (da) begin
        ma[k] = (ma[k] & ~(32'hF << (4 * pa[k]))) | (int'(val) << (4 * pa[k]));
        fa[k] = 0;
        pa[k]++;
        if (pa[k] == nch[k]) begin pa[k] = 0; fa[k] = 1; end
      end
      if (db) begin
        mb[k] = (mb[k] & ~(32'hF << (4 * pb[k]))) | (int'(val) << (4 * pb[k]));
        fb[k] = 0;
        pb[k]++;
        if (pb[k] == nch[k]) begin pb[k] = 0; fb[k] = 1; end
      end
      if ((da || db) && fa[k] && fb[k]) begin
        cmp_e[k] = p;
        exp_q[k].push_back('{res: ref_cmp(ma[k], mb[k], 4 * nch[k], sm[k]), due: p + nch[k]});
      end
    end
    y[k] = val;
    if (da) ld_a[k] = 1'b1;
    if (db) ld_b[k] = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    if (da) ld_a[k] = 1'b0;
    if (db) ld_b[k] = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_op(input int k, input int sel, input int val);
    for (int i = 0; i < nch[k]; i++)
      press(k, sel == 0, sel == 1, 4'((val >> (4 * i)) & 15), $urandom_range(3, 6));
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain%0d", k), exp_q[k].size(), 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset[k] && valid[k] && !pv[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_valid%0d", k), 1, 0);
        end else begin
          exp_t e;
          e = exp_q[k].pop_front();
          check($sformatf("result%0d", k), {l0[k], l1[k], l2[k]}, e.res);
          check($sformatf("latency%0d", k), cyc, e.due);
        end
      end
      pv[k] <= valid[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    nch[0] = 2;
    nch[1] = 4;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; y[k] = '0; ld_a[k] = 1'b0; ld_b[k] = 1'b0; sm[k] = 1'b0; pv[k] = 1'b0;
      model_reset(k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("reset_outs%0d", k), {l0[k], l1[k], l2[k], valid[k], busy[k]}, 0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);

    // Equal operands, unsigned.
    load_op(0, 0, 'h21);
    load_op(0, 1, 'h21);
    wait_drain(0);

    // 0x80 vs 0x7F: unsigned greater, then signed less after reloading B only.
    load_op(0, 0, 'h80);
    load_op(0, 1, 'h7F);
    wait_drain(0);
    sm[0] = 1'b1;
    load_op(0, 1, 'h7F);
    wait_drain(0);

    // Decision from the low chunk.
    sm[0] = 1'b0;
    load_op(0, 0, 'h35);
    load_op(0, 1, 'h3A);
    wait_drain(0);

    // A press landing one edge into the compare is dropped.
    load_op(0, 0, 'h12);
    press(0, 0, 1, 4'h4, 4);
    fork
      press(0, 0, 1, 4'h9, 4);
      begin
        @(negedge clk);
        press(0, 1, 0, 4'h9, 4);
      end
    join
    wait_drain(0);
    check("drop_a_reg", u_dut0.a_reg, ma[0]);
    check("drop_ptr_a", u_dut0.ptr_a, pa[0]);
    check("drop_model", ma[0], 'h12);

    // Button held for 50 cycles loads exactly one chunk.
    press(0, 0, 1, 4'hC, 50);
    check("hold_ptr_b", u_dut0.ptr_b, 1);
    press(0, 0, 1, 4'h0, 4);
    wait_drain(0);

    // Reset one cycle into a compare.
    load_op(0, 0, 'h44);
    press(0, 0, 1, 4'h1, 4);
    e0 = cyc + SYNC + 1;
    fork
      press(0, 0, 1, 4'h2, 4);
      begin
        wait (cyc == e0 + 1);
        #2;
        check("busy_before_rst", busy[0], 1);
        reset[0] = 1'b1;
        #1;
        check("rst_outs", {l0[0], l1[0], l2[0], valid[0], busy[0]}, 0);
      end
    join
    model_reset(0);
    @(negedge clk);
    reset[0] = 1'b0;
    @(negedge clk);
    check("rst_ptr_a", u_dut0.ptr_a, 0);
    check("rst_ptr_b", u_dut0.ptr_b, 0);
    check("rst_full", {u_dut0.full_a, u_dut0.full_b}, 0);
    check("rst_state", int'(u_dut0.state), int'(IDLE));
    check("rst_no_result", valid[0], 0);

    // Four-chunk instance: simultaneous presses, then -1 vs 1.
    sm[1] = 1'b1;
    for (int i = 0; i < 4; i++) press(1, 1, 1, (i % 2 == 0) ? 4'hA : 4'h5, 4);
    wait_drain(1);
    sm[1] = 1'b0;
    load_op(1, 0, 'hFFFF);
    load_op(1, 1, 'h0001);
    wait_drain(1);
    sm[1] = 1'b1;
    load_op(1, 0, 'hFFFF);
    wait_drain(1);

    // Random operands, modes and reload patterns.
    for (int k = 0; k < 2; k++) begin
      for (int it = 0; it < 10; it++) begin
        int a, b, mode, mask;
        mask = (1 << (4 * nch[k])) - 1;
        a    = int'($urandom) & mask;
        b    = (it % 3 == 0) ? a : (int'($urandom) & mask);
        mode = (it < 2) ? 0 : int'($urandom_range(0, 2));
        sm[k] = 1'($urandom_range(0, 1));
        if (mode != 2) load_op(k, 0, a);
        if (mode != 1) load_op(k, 1, b);
        wait_drain(k);
      end
    end

    repeat (5) @(negedge clk);
    check("final_q0", exp_q[0].size(), 0);
    check("final_q1", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
